instruction_fetch: RTL and testbench

Instruction fetch unit for the MIPS datapath. It holds the program counter and drives the address of the instruction memory, which has a 10-bit address and a 32-bit combinational read. It registers the returned word into an instruction register for decode. It also selects which resident program runs (fibonacci, factorial, synthetic), absorbs unconditional jumps locally, accepts branch redirects and stalls from downstream, and detects halt.

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/instruction_fetch_if.sv | 35 +++
 rtl/instruction_fetch_pc_next_sel.sv | 71 +++++++
 rtl/instruction_fetch.sv | 100 ++++++++++
 tb/tb_instruction_fetch.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: memory geometry, opcodes, resident
// program entry points, fetch FSM encoding and the fetch action codes
// produced by the next-PC selector.
package mips_pkg;

  localparam int ADDR_W     = 10;
  localparam int INSTR_W    = 32;
  localparam int MEM_TOP    = 80;
  localparam int PROG1_BASE = 1;   // fibonacci
  localparam int PROG2_BASE = 15;  // factorial
  localparam int PROG3_BASE = 30;  // synthetic

  localparam logic [5:0] OP_JUMP = 6'b010000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_LD   = 6'b100011;
  localparam logic [5:0] OP_LDI  = 6'b001111;
  localparam logic [5:0] OP_ST   = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  // What the fetch unit does on the coming edge.
  typedef enum logic [2:0] {
    ACT_HOLD     = 3'd0,
    ACT_RESTART  = 3'd1,
    ACT_REDIRECT = 3'd2,
    ACT_HALT     = 3'd3,
    ACT_JUMP     = 3'd4,
    ACT_ISSUE    = 3'd5
  } fetch_act_t;

  // Entry address of the resident program chosen by prog_sel.
  function automatic logic [ADDR_W-1:0] prog_base(input logic [1:0] sel);
    logic [ADDR_W-1:0] base;
    case (sel)
      2'd2:    base = ADDR_W'(PROG2_BASE);
      2'd3:    base = ADDR_W'(PROG3_BASE);
      default: base = ADDR_W'(PROG1_BASE);
    endcase
    return base;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Control and memory bus of the instruction fetch unit.
// master: environment (control, downstream stages, instruction memory).
// slave : the fetch unit itself.
//   start/prog_sel       program launch
//   stall                downstream back-pressure
//   branch_taken/_target execute-stage redirect
//   address/instrucao    instruction memory read (combinational)
//   instr_out/pc_out/instr_valid  instruction register to decode
//   halted               fetch stopped at end of program
interface instruction_fetch_if;
  import mips_pkg::*;

  logic                 start;
  logic [1:0]           prog_sel;
  logic                 stall;
  logic                 branch_taken;
  logic [ADDR_W-1:0]    branch_target;
  logic [ADDR_W-1:0]    address;
  logic [INSTR_W-1:0]   instrucao;
  logic [INSTR_W-1:0]   instr_out;
  logic [ADDR_W-1:0]    pc_out;
  logic                 instr_valid;
  logic                 halted;

  modport master (
    output start, prog_sel, stall, branch_taken, branch_target, instrucao,
    input  address, instr_out, pc_out, instr_valid, halted
  );

  modport slave (
    input  start, prog_sel, stall, branch_taken, branch_target, instrucao,
    output address, instr_out, pc_out, instr_valid, halted
  );

endinterface

// File: rtl/instruction_fetch_pc_next_sel.sv
// pc_next_sel: combinational next-PC mux of the fetch unit. Resolves the
// start / branch / stall / halt / jump / sequential priority and reports
// both the next address and the action the register stage must take.
//   state, start, prog_sel, stall, branch_taken, branch_target : controls
//   address   : current PC
//   opcode    : instrucao[31:26] of the word at address
//   jump_addr : instrucao[ADDR_W-1:0], target of an absorbed jump
//   next_address, action : outputs
module pc_next_sel
  import mips_pkg::*;
(
  input  fetch_state_t       state,
  input  logic               start,
  input  logic [1:0]         prog_sel,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [ADDR_W-1:0]  address,
  input  logic [5:0]         opcode,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [ADDR_W-1:0]  next_address,
  output fetch_act_t         action
);

  localparam logic [ADDR_W-1:0] MEM_TOP_A = ADDR_W'(MEM_TOP);

  // Priority-ordered selection of the next PC and fetch action.
  always_comb begin
    next_address = address;
    action       = ACT_HOLD;
    case (state)
      ST_IDLE, ST_HALT: begin
        // Branches are ignored outside FETCH; only start leaves these states.
        if (start) begin
          next_address = prog_base(prog_sel);
          action       = ACT_RESTART;
        end else begin
          next_address = address;
          action       = ACT_HOLD;
        end
      end
      ST_FETCH: begin
        if (start) begin
          next_address = prog_base(prog_sel);
          action       = ACT_RESTART;
        end else if (branch_taken) begin
          // Redirect beats stall: the held word is squashed.
          next_address = branch_target;
          action       = ACT_REDIRECT;
        end else if (stall) begin
          next_address = address;
          action       = ACT_HOLD;
        end else if ((opcode == OP_HALT) || (address > MEM_TOP_A)) begin
          next_address = address;
          action       = ACT_HALT;
        end else if (opcode == OP_JUMP) begin
          next_address = jump_addr;
          action       = ACT_JUMP;
        end else begin
          next_address = address + ADDR_W'(1);
          action       = ACT_ISSUE;
        end
      end
      default: begin
        next_address = address;
        action       = ACT_HOLD;
      end
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter, instruction register and run/halt
// control for the MIPS datapath.
//   clock   : system clock, rising edge
//   reset_n : asynchronous active-low reset (returns to IDLE, outputs 0)
//   bus     : instruction_fetch_if.slave (controls, memory read, IR to decode)
// Unconditional jumps are absorbed here and never reach decode.
module instruction_fetch
  import mips_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  instruction_fetch_if.slave    bus
);

  fetch_state_t        state_r, state_s;
  logic [ADDR_W-1:0]   address_r, address_s;
  logic [INSTR_W-1:0]  instr_out_r, instr_out_s;
  logic [ADDR_W-1:0]   pc_out_r, pc_out_s;
  logic                instr_valid_r, instr_valid_s;
  logic                halted_r, halted_s;

  logic [ADDR_W-1:0]   next_address_s;
  fetch_act_t          action_s;

  pc_next_sel u_pc_next_sel (
    .state         (state_r),
    .start         (bus.start),
    .prog_sel      (bus.prog_sel),
    .stall         (bus.stall),
    .branch_taken  (bus.branch_taken),
    .branch_target (bus.branch_target),
    .address       (address_r),
    .opcode        (bus.instrucao[INSTR_W-1:INSTR_W-6]),
    .jump_addr     (bus.instrucao[ADDR_W-1:0]),
    .next_address  (next_address_s),
    .action        (action_s)
  );

  // Next-state and next-output decode from the selected fetch action.
  always_comb begin
    state_s       = state_r;
    address_s     = next_address_s;
    instr_out_s   = instr_out_r;
    pc_out_s      = pc_out_r;
    instr_valid_s = instr_valid_r;
    halted_s      = halted_r;
    case (action_s)
      ACT_RESTART: begin
        state_s       = ST_FETCH;
        instr_valid_s = 1'b0;
        halted_s      = 1'b0;
      end
      ACT_REDIRECT, ACT_JUMP: begin
        instr_valid_s = 1'b0;
      end
      ACT_HALT: begin
        state_s       = ST_HALT;
        instr_valid_s = 1'b0;
        halted_s      = 1'b1;
      end
      ACT_ISSUE: begin
        instr_out_s   = bus.instrucao;
        pc_out_s      = address_r;
        instr_valid_s = 1'b1;
      end
      ACT_HOLD: begin
        instr_valid_s = instr_valid_r;
      end
      default: begin
        instr_valid_s = 1'b0;
      end
    endcase
  end

  // State, PC and instruction register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= ST_IDLE;
      address_r     <= '0;
      instr_out_r   <= '0;
      pc_out_r      <= '0;
      instr_valid_r <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      address_r     <= address_s;
      instr_out_r   <= instr_out_s;
      pc_out_r      <= pc_out_s;
      instr_valid_r <= instr_valid_s;
      halted_r      <= halted_s;
    end
  end

  assign bus.address     = address_r;
  assign bus.instr_out   = instr_out_r;
  assign bus.pc_out      = pc_out_r;
  assign bus.instr_valid = instr_valid_r;
  assign bus.halted      = halted_r;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: per-cycle vector table for address, valid,
// pc_out and halted, plus a scoreboard of issued (pc, word) pairs, and a
// hand-written asynchronous reset sequence.
module tb_instruction_fetch;
  import mips_pkg::*;

  logic clock;
  logic reset_n;
  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  logic [INSTR_W-1:0] mem [0:1023];
  assign bus.instrucao = mem[bus.address];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic              start;
    logic [1:0]        sel;
    logic              stall;
    logic              br;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_valid;
    logic [ADDR_W-1:0] exp_pc;
    logic              exp_halted;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] word;
  } issue_t;

  vec_t   vecs[$];
  issue_t sb[$];
  int     total  = 0;
  int     passed = 0;

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    else
      passed++;
  endtask

  task automatic add(input logic st, input logic [1:0] sel, input logic stl,
                     input logic br, input int tgt, input int ea,
                     input logic ev, input int ep, input logic eh);
    vec_t v;
    v.start = st; v.sel = sel; v.stall = stl; v.br = br;
    v.tgt = ADDR_W'(tgt); v.exp_addr = ADDR_W'(ea); v.exp_valid = ev;
    v.exp_pc = ADDR_W'(ep); v.exp_halted = eh;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t   v;
    issue_t e;

    for (int i = 0; i < 1024; i++) mem[i] = {6'b001000, 26'(i * 1031 + 7)};
    mem[24] = {6'b010000, 16'h0000, 10'd21};  // jump to 21
    mem[36] = {6'b111111, 26'd0};             // halt

    // factorial entry, sequential 15..23, jump at 24 back to 21
    add(1'b1, 2'd2, 1'b0, 1'b0, 0, 15, 1'b0, 0, 1'b0);
    for (int k = 1; k <= 9; k++) add(1'b0, 2'd2, 1'b0, 1'b0, 0, 15 + k, 1'b1, 14 + k, 1'b0);
    add(1'b0, 2'd2, 1'b0, 1'b0, 0, 21, 1'b0, 23, 1'b0);
    add(1'b0, 2'd2, 1'b0, 1'b0, 0, 22, 1'b1, 21, 1'b0);
    // restart at fibonacci entry, run to address 9, stall 3 cycles
    add(1'b1, 2'd1, 1'b0, 1'b0, 0, 1, 1'b0, 21, 1'b0);
    for (int k = 1; k <= 8; k++) add(1'b0, 2'd1, 1'b0, 1'b0, 0, 1 + k, 1'b1, k, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b0, 2'd1, 1'b1, 1'b0, 0, 9, 1'b1, 8, 1'b0);
    add(1'b0, 2'd1, 1'b0, 1'b0, 0, 10, 1'b1, 9, 1'b0);
    // branch while stalled at 10 -> 61, then run off the end of memory
    add(1'b0, 2'd1, 1'b1, 1'b1, 61, 61, 1'b0, 9, 1'b0);
    for (int k = 61; k <= 80; k++) add(1'b0, 2'd1, 1'b0, 1'b0, 0, k + 1, 1'b1, k, 1'b0);
    add(1'b0, 2'd1, 1'b0, 1'b0, 0, 81, 1'b0, 80, 1'b1);
    add(1'b0, 2'd1, 1'b0, 1'b1, 5, 81, 1'b0, 80, 1'b1);  // branch ignored in HALT
    // synthetic program hits OP_HALT at 36
    add(1'b1, 2'd3, 1'b0, 1'b0, 0, 30, 1'b0, 80, 1'b0);
    for (int k = 30; k <= 35; k++) add(1'b0, 2'd3, 1'b0, 1'b0, 0, k + 1, 1'b1, k, 1'b0);
    add(1'b0, 2'd3, 1'b0, 1'b0, 0, 36, 1'b0, 35, 1'b1);
    add(1'b0, 2'd3, 1'b0, 1'b0, 0, 36, 1'b0, 35, 1'b1);
    add(1'b1, 2'd1, 1'b0, 1'b0, 0, 1, 1'b0, 35, 1'b0);
    add(1'b0, 2'd1, 1'b0, 1'b0, 0, 2, 1'b1, 1, 1'b0);
    // start beats branch (prog_sel 0 maps to fibonacci), then plain branch
    add(1'b1, 2'd0, 1'b0, 1'b1, 50, 1, 1'b0, 1, 1'b0);
    add(1'b0, 2'd0, 1'b0, 1'b0, 0, 2, 1'b1, 1, 1'b0);
    add(1'b0, 2'd0, 1'b0, 1'b1, 40, 40, 1'b0, 1, 1'b0);
    add(1'b0, 2'd0, 1'b0, 1'b0, 0, 41, 1'b1, 40, 1'b0);
    add(1'b0, 2'd0, 1'b0, 1'b0, 0, 42, 1'b1, 41, 1'b0);

    // reset
    reset_n = 1'b0;
    bus.start = 1'b0; bus.prog_sel = 2'd0; bus.stall = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_address", -1, 32'(bus.address), 32'd0);
    check("rst_instr_out", -1, bus.instr_out, 32'd0);
    check("rst_pc_out", -1, 32'(bus.pc_out), 32'd0);
    check("rst_valid", -1, 32'(bus.instr_valid), 32'd0);
    check("rst_halted", -1, 32'(bus.halted), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // table-driven run with issue scoreboard
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      bus.start = v.start; bus.prog_sel = v.sel; bus.stall = v.stall;
      bus.branch_taken = v.br; bus.branch_target = v.tgt;
      if (v.exp_valid && !v.stall) sb.push_back('{v.exp_pc, mem[v.exp_pc]});
      @(posedge clock);
      #1;
      check("address", i, 32'(bus.address), 32'(v.exp_addr));
      check("instr_valid", i, 32'(bus.instr_valid), 32'(v.exp_valid));
      check("pc_out", i, 32'(bus.pc_out), 32'(v.exp_pc));
      check("halted", i, 32'(bus.halted), 32'(v.exp_halted));
      if (v.exp_valid && v.stall)
        check("ir_hold", i, bus.instr_out, mem[v.exp_pc]);
      if (bus.instr_valid && !v.stall) begin
        if (sb.size() == 0) begin
          check("unexpected_issue", i, 32'(bus.pc_out), 32'h0000_FFFF);
        end else begin
          e = sb.pop_front();
          check("sb_pc", i, 32'(bus.pc_out), 32'(e.pc));
          check("sb_instr", i, bus.instr_out, e.word);
        end
      end
    end
    check("sb_empty", -1, 32'(sb.size()), 32'd0);
    bus.start = 1'b0; bus.stall = 1'b0; bus.branch_taken = 1'b0;

    // asynchronous reset in the middle of FETCH, no clock edge involved
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_address", -2, 32'(bus.address), 32'd0);
    check("arst_instr_out", -2, bus.instr_out, 32'd0);
    check("arst_pc_out", -2, 32'(bus.pc_out), 32'd0);
    check("arst_valid", -2, 32'(bus.instr_valid), 32'd0);
    check("arst_halted", -2, 32'(bus.halted), 32'd0);
    #2;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("idle_address", -3, 32'(bus.address), 32'd0);
    check("idle_valid", -3, 32'(bus.instr_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
